// File: rtl/cricket_match_engine.sv
// Two-innings cricket match engine driven by a free-running Galois LFSR.
// Tracks score, wickets, overs and innings, and decides win, loss or tie.
module cricket_match_engine #(
    parameter int             OVERS          = 20,
    parameter int             BALLS_PER_OVER = 6,
    parameter int             MAX_WICKETS    = 10,
    parameter int             RUN_W          = 9,
    parameter int             LFSR_W         = 8,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = 8'hB8,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'h01
) (
    input  logic             clk_fpga,
    input  logic             reset_n,
    input  logic             start,
    input  logic             delivery,
    input  logic             force_en,
    input  logic [3:0]       force_code,
    output logic [RUN_W-1:0] runs,
    output logic [3:0]       wickets,
    output logic [5:0]       overs_done,
    output logic [2:0]       ball_in_over,
    output logic             innings,
    output logic [RUN_W:0]   target,
    output logic [3:0]       last_outcome,
    output logic             outcome_valid,
    output logic             inningOver,
    output logic             gameOver,
    output logic [1:0]       winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INN1,
        S_BREAK,
        S_INN2,
        S_DONE
    } state_t;

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [LFSR_W-1:0] SEED =
        (LFSR_SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : LFSR_SEED;

    localparam logic [3:0] CODE_WIDE   = 4'd13;
    localparam logic [3:0] CODE_NOBALL = 4'd14;
    localparam logic [3:0] CODE_WKT    = 4'd15;

    state_t            state;
    state_t            state_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic [3:0]        code;
    logic [RUN_W:0]    add;
    logic [RUN_W:0]    sum;
    logic [RUN_W-1:0]  runs_nxt;
    logic [3:0]        wk_nxt;
    logic [2:0]        bio_nxt;
    logic [5:0]        overs_nxt;
    logic              take;
    logic              legal;
    logic              all_out;
    logic              overs_out;
    logic              inn_end;
    logic              chase;

    // Free-running Galois LFSR; steps on every clock in every state.
    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    // Decode the ball outcome and compute the post-ball score.
    always_comb begin
        code      = force_en ? force_code : lfsr[3:0];
        take      = delivery && (state == S_INN1 || state == S_INN2);
        legal     = (code != CODE_WIDE) && (code != CODE_NOBALL);
        add       = '0;
        unique case (code)
            4'd0, 4'd1, 4'd2:             add = '0;
            4'd3, 4'd4, 4'd5, 4'd6:       add = (RUN_W+1)'(1);
            4'd7, 4'd8, 4'd9:             add = (RUN_W+1)'(2);
            4'd10:                        add = (RUN_W+1)'(3);
            4'd11:                        add = (RUN_W+1)'(4);
            4'd12:                        add = (RUN_W+1)'(6);
            4'd13, 4'd14:                 add = (RUN_W+1)'(1);
            4'd15:                        add = '0;
        endcase
        sum       = {1'b0, runs} + add;
        runs_nxt  = sum[RUN_W] ? '1 : sum[RUN_W-1:0];
        wk_nxt    = wickets + {3'd0, code == CODE_WKT};
        bio_nxt   = ball_in_over;
        overs_nxt = overs_done;
        if (legal) begin
            if (ball_in_over == 3'(BALLS_PER_OVER - 1)) begin
                bio_nxt   = '0;
                overs_nxt = overs_done + 6'd1;
            end else begin
                bio_nxt   = ball_in_over + 3'd1;
            end
        end
        all_out   = (wk_nxt == 4'(MAX_WICKETS));
        overs_out = (overs_nxt == 6'(OVERS));
        inn_end   = all_out || overs_out;
        chase     = (state == S_INN2) && ({1'b0, runs_nxt} >= target);
    end

    // Match state register.
    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing and state-derived flags.
    always_comb begin
        state_nxt  = state;
        inningOver = 1'b0;
        gameOver   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INN1;
            end
            S_INN1: begin
                if (take && inn_end) state_nxt = S_BREAK;
            end
            S_BREAK: begin
                inningOver = 1'b1;
                if (start) state_nxt = S_INN2;
            end
            S_INN2: begin
                if (take && (chase || inn_end)) state_nxt = S_DONE;
            end
            S_DONE: begin
                inningOver = 1'b1;
                gameOver   = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Scoreboard counters, target capture and result.
    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            runs          <= '0;
            wickets       <= '0;
            overs_done    <= '0;
            ball_in_over  <= '0;
            innings       <= 1'b0;
            target        <= '0;
            last_outcome  <= '0;
            outcome_valid <= 1'b0;
            winner        <= 2'b00;
        end else begin
            outcome_valid <= 1'b0;
            if (state == S_BREAK && start) begin
                runs         <= '0;
                wickets      <= '0;
                overs_done   <= '0;
                ball_in_over <= '0;
                innings      <= 1'b1;
            end else if (take) begin
                runs          <= runs_nxt;
                wickets       <= wk_nxt;
                overs_done    <= overs_nxt;
                ball_in_over  <= bio_nxt;
                last_outcome  <= code;
                outcome_valid <= 1'b1;
                if (state == S_INN1 && inn_end) begin
                    target <= {1'b0, runs_nxt} + (RUN_W+1)'(1);
                end
                if (state == S_INN2) begin
                    if (chase) begin
                        winner <= 2'b10;
                    end else if (inn_end) begin
                        // Team 2 can at most level the score without chasing.
                        winner <= ({1'b0, runs_nxt} == target - (RUN_W+1)'(1))
                                  ? 2'b11 : 2'b01;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cricket_match_engine.sv
// Randomized and directed bench for cricket_match_engine.
// Compares every cycle against a score-keeping model of the match rules.
module tb_cricket_match_engine;

    logic       clk_fpga = 1'b0;
    logic       reset_n  = 1'b0;
    logic       start = 1'b0, delivery = 1'b0, force_en = 1'b0;
    logic [3:0] force_code = '0;

    logic [8:0] runs;
    logic [3:0] wickets;
    logic [5:0] overs_done;
    logic [2:0] ball_in_over;
    logic       innings;
    logic [9:0] target;
    logic [3:0] last_outcome;
    logic       outcome_valid, inningOver, gameOver;
    logic [1:0] winner;

    logic       s_start = 1'b0, s_delivery = 1'b0;
    logic [3:0] s_runs, s_wickets, s_last;
    logic [5:0] s_overs;
    logic [2:0] s_bio;
    logic       s_innings, s_valid, s_io, s_go;
    logic [4:0] s_target;
    logic [1:0] s_winner;

    always #5 clk_fpga = ~clk_fpga;

    cricket_match_engine dut (
        .clk_fpga(clk_fpga), .reset_n(reset_n), .start(start),
        .delivery(delivery), .force_en(force_en), .force_code(force_code),
        .runs(runs), .wickets(wickets), .overs_done(overs_done),
        .ball_in_over(ball_in_over), .innings(innings), .target(target),
        .last_outcome(last_outcome), .outcome_valid(outcome_valid),
        .inningOver(inningOver), .gameOver(gameOver), .winner(winner)
    );

    cricket_match_engine #(.RUN_W(4)) dut_sat (
        .clk_fpga(clk_fpga), .reset_n(reset_n), .start(s_start),
        .delivery(s_delivery), .force_en(1'b1), .force_code(4'd12),
        .runs(s_runs), .wickets(s_wickets), .overs_done(s_overs),
        .ball_in_over(s_bio), .innings(s_innings), .target(s_target),
        .last_outcome(s_last), .outcome_valid(s_valid),
        .inningOver(s_io), .gameOver(s_go), .winner(s_winner)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 innings 1, 2 break, 3 innings 2, 4 done.
    int       m_phase, m_runs, m_wk, m_balls, m_target, m_win;
    int       m_last, m_valid, m_inn;
    bit [7:0] m_lfsr;
    int       valid_seen;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int runs_for(input int c);
        if (c <= 2) return 0;
        if (c <= 6) return 1;
        if (c <= 9) return 2;
        if (c == 10) return 3;
        if (c == 11) return 4;
        if (c == 12) return 6;
        if (c == 15) return 0;
        return 1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_runs = 0; m_wk = 0; m_balls = 0;
        m_target = 0; m_win = 0; m_last = 0; m_valid = 0; m_inn = 0;
        m_lfsr = 8'h01;
    endtask

    task automatic model_clock(input bit st, input bit dl,
                               input bit fe, input int fc);
        int c;
        m_valid = 0;
        if (st && m_phase == 0) begin
            m_phase = 1;
        end else if (st && m_phase == 2) begin
            m_phase = 3; m_inn = 1;
            m_runs = 0; m_wk = 0; m_balls = 0;
        end else if (dl && (m_phase == 1 || m_phase == 3)) begin
            c = fe ? fc : int'(m_lfsr[3:0]);
            m_last = c; m_valid = 1;
            m_runs = m_runs + runs_for(c);
            if (m_runs > 511) m_runs = 511;
            if (c != 13 && c != 14) m_balls++;
            if (c == 15) m_wk++;
            if (m_phase == 3 && m_runs >= m_target) begin
                m_phase = 4; m_win = 2;
            end else if (m_wk == 10 || m_balls == 120) begin
                if (m_phase == 1) begin
                    m_phase = 2; m_target = m_runs + 1;
                end else begin
                    m_phase = 4;
                    m_win = (m_runs == m_target - 1) ? 3 : 1;
                end
            end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
    endtask

    task automatic check_all();
        check("runs", runs, m_runs);
        check("wickets", wickets, m_wk);
        check("overs_done", overs_done, m_balls / 6);
        check("ball_in_over", ball_in_over, m_balls % 6);
        check("innings", innings, m_inn);
        check("target", target, m_target);
        check("last_outcome", last_outcome, m_last);
        check("outcome_valid", outcome_valid, m_valid);
        check("inningOver", inningOver, int'(m_phase == 2 || m_phase == 4));
        check("gameOver", gameOver, int'(m_phase == 4));
        check("winner", winner, m_win);
    endtask

    task automatic step(input bit st, input bit dl,
                        input bit fe, input int fc);
        start = st; delivery = dl; force_en = fe; force_code = 4'(fc);
        @(posedge clk_fpga);
        model_clock(st, dl, fe, fc);
        #1;
        if (outcome_valid) valid_seen++;
        check_all();
        start = 1'b0; delivery = 1'b0;
    endtask

    task automatic ball(input int code, input int n);
        for (int i = 0; i < n; i++) step(0, 1, 1, code);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic apply_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk_fpga);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        valid_seen = 0;
        @(posedge clk_fpga);
        #1;
        apply_reset();

        // Dot balls complete one over.
        step(1, 0, 0, 0);
        valid_seen = 0;
        ball(0, 6);
        check("dots_overs", overs_done, 1);
        check("dots_bio", ball_in_over, 0);
        check("dots_valid_count", valid_seen, 6);

        // Wide, no-ball, six.
        apply_reset();
        step(1, 0, 0, 0);
        ball(13, 1);
        ball(14, 1);
        ball(12, 1);
        check("extras_runs", runs, 8);
        check("extras_bio", ball_in_over, 1);

        // All out; later deliveries ignored, start+delivery in break.
        apply_reset();
        step(1, 0, 0, 0);
        ball(15, 10);
        check("allout_inningover", inningOver, 1);
        check("allout_target", target, 1);
        valid_seen = 0;
        ball(12, 3);
        check("allout_no_valid", valid_seen, 0);
        step(1, 1, 1, 12);
        check("break_start_wins_runs", runs, 0);

        // Chase: 12 then overs exhausted, team 2 hits fours.
        apply_reset();
        step(1, 0, 0, 0);
        ball(12, 2);
        ball(0, 118);
        check("chase_target", target, 13);
        step(1, 0, 0, 0);
        ball(11, 3);
        check("chase_not_yet", gameOver, 0);
        ball(11, 1);
        check("chase_gameover", gameOver, 1);
        check("chase_winner", winner, 2);

        // Tie.
        apply_reset();
        step(1, 0, 0, 0);
        ball(12, 1);
        ball(15, 10);
        step(1, 0, 0, 0);
        ball(12, 1);
        ball(15, 10);
        check("tie_winner", winner, 3);

        // Team 1 win, then reset mid second innings.
        apply_reset();
        step(1, 0, 0, 0);
        ball(12, 1);
        ball(15, 10);
        step(1, 0, 0, 0);
        ball(11, 1);
        ball(3, 1);
        ball(15, 10);
        check("t1_winner", winner, 1);
        apply_reset();
        step(1, 0, 0, 0);
        ball(15, 10);
        step(1, 0, 0, 0);
        ball(7, 2);
        apply_reset();

        // Randomized play, including LFSR-driven outcomes.
        for (int i = 0; i < 1500; i++) begin
            if (m_phase == 4) apply_reset();
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)));
        end

        // Saturation with narrow run counters.
        apply_reset();
        s_start = 1'b1;
        step(0, 0, 0, 0);
        s_start = 1'b0;
        s_delivery = 1'b1;
        step(0, 0, 0, 0);
        check("sat_6", s_runs, 6);
        step(0, 0, 0, 0);
        check("sat_12", s_runs, 12);
        step(0, 0, 0, 0);
        check("sat_15", s_runs, 15);
        step(0, 0, 0, 0);
        s_delivery = 1'b0;
        check("sat_hold", s_runs, 15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
